seq_frame_ctrl: RTL and testbench

SEQ_FRAME_CTRL -- requirements
Module: seq_frame_ctrl

---
 rtl/seq_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_seq_frame_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_ctrl.sv
// Serial frame controller: sync-pattern detect, address/length header, per-channel payload steering.
// Define SEQ_FRAME_CTRL_STATUS_EN to add the 8-bit frame_cnt status output.
module seq_frame_ctrl #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int              ADDR_W  = 2,
    parameter int              LEN_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    input  logic                  abort,
    output logic [2**ADDR_W-1:0]  dout,
    output logic [2**ADDR_W-1:0]  ch_valid,
    output logic                  busy,
    output logic                  done
`ifdef SEQ_FRAME_CTRL_STATUS_EN
    ,
    output logic [7:0]            frame_cnt
`endif
);

    localparam int HDR_W  = ADDR_W + LEN_W;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int HCNT_W = $clog2(HDR_W);

    typedef enum logic [1:0] {
        DETECT,
        HEADER,
        PAYLOAD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PAT_W-2:0]  hist;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill;
    logic [HCNT_W-1:0] hdr_cnt;
    logic [LEN_W-1:0]  pay_cnt;
    logic [HDR_W-1:0]  hdr;
    logic [HDR_W-1:0]  hdr_next;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              match;
    logic              hdr_last;
    logic              pay_last;
    logic              complete;

    // Address and length share one shift register; the address field lands in the upper bits.
    assign addr = hdr[HDR_W-1:LEN_W];
    assign len  = hdr[LEN_W-1:0];
    assign busy = (state != DETECT);

    always_comb begin
        hist_next  = {hist, serial_in};
        hdr_next   = {hdr[HDR_W-2:0], serial_in};
        match      = (fill >= FILL_W'(PAT_W - 1)) && (hist_next == PATTERN);
        hdr_last   = (hdr_cnt == HCNT_W'(HDR_W - 1));
        pay_last   = ((pay_cnt + 1'b1) == len);
        state_next = state;
        complete   = 1'b0;
        dout       = '0;
        ch_valid   = '0;
        case (state)
            DETECT: begin
                if (serial_valid && match) state_next = HEADER;
            end
            HEADER: begin
                if (serial_valid && hdr_last) begin
                    if (hdr_next[LEN_W-1:0] == '0) begin
                        state_next = DETECT;
                        complete   = 1'b1;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                dout[addr]     = serial_in;
                ch_valid[addr] = serial_valid;
                if (serial_valid && pay_last) begin
                    state_next = DETECT;
                    complete   = 1'b1;
                end
            end
            default: state_next = DETECT;
        endcase
        if (abort) begin
            state_next = DETECT;
            complete   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DETECT;
            hist    <= '0;
            fill    <= '0;
            hdr_cnt <= '0;
            pay_cnt <= '0;
            hdr     <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= complete;

            // History only accumulates while idling in DETECT; any other path re-enters it clean.
            if (state != DETECT || state_next != DETECT || abort) begin
                hist <= '0;
                fill <= '0;
            end else if (serial_valid) begin
                hist <= hist_next[PAT_W-2:0];
                if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
            end

            if (state_next != HEADER) begin
                hdr_cnt <= '0;
            end else if (state == HEADER && serial_valid) begin
                hdr_cnt <= hdr_cnt + 1'b1;
            end

            if (state == HEADER && serial_valid) hdr <= hdr_next;

            if (state_next != PAYLOAD) begin
                pay_cnt <= '0;
            end else if (state == PAYLOAD && serial_valid) begin
                pay_cnt <= pay_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_FRAME_CTRL_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (complete) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Self-checking bench for seq_frame_ctrl: directed frames plus random streams against a
// frame-parsing reference model that re-scans the consumed bits of the current frame.
module tb_seq_frame_ctrl;

    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         ADDR_W  = 2;
    localparam int         LEN_W   = 3;
    localparam int         HDR_W   = ADDR_W + LEN_W;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b0;
    logic       serial_valid = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] dout;
    logic [3:0] ch_valid;
    logic       busy;
    logic       done;
`ifdef SEQ_FRAME_CTRL_STATUS_EN
    logic [7:0] frame_cnt;
`endif

    seq_frame_ctrl #(
        .PAT_W  (PAT_W),
        .PATTERN(PATTERN),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .abort       (abort),
        .dout        (dout),
        .ch_valid    (ch_valid),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_FRAME_CTRL_STATUS_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          seg[$];
    bit          m_done = 1'b0;
    int unsigned m_fc = 0;
    logic [3:0]  exp_dout;
    logic [3:0]  exp_cv;
    logic [9:0]  obs;
    logic [9:0]  exp_v;
    logic [7:0]  obs_fc;
    logic [7:0]  exp_fc;

    // Phase of the current frame from the bits consumed since it began:
    // 0 hunting, 1 header, 2 payload, 3 frame complete.
    function automatic void analyze(output int ph, output int a, output int l, output int p);
        int k = -1;
        int v;
        int h;
        ph = 0; a = 0; l = 0; p = 0;
        for (int i = PAT_W - 1; i < seg.size(); i++) begin
            v = 0;
            for (int j = 0; j < PAT_W; j++) v = v * 2 + int'(seg[i-PAT_W+1+j]);
            if (v == int'(PATTERN)) begin
                k = i;
                break;
            end
        end
        if (k < 0) return;
        h = seg.size() - 1 - k;
        if (h < HDR_W) begin
            ph = 1;
            return;
        end
        for (int j = 0; j < ADDR_W; j++) a = a * 2 + int'(seg[k+1+j]);
        for (int j = 0; j < LEN_W; j++) l = l * 2 + int'(seg[k+1+ADDR_W+j]);
        p = h - HDR_W;
        ph = (p >= l) ? 3 : 2;
    endfunction

    // Drive one cycle, capture observed and predicted outputs before the edge, then advance the model.
    task automatic cycle(input logic b, input logic v, input logic ab, input logic r);
        int ph, a, l, p;
        @(negedge clk);
        serial_in = b; serial_valid = v; abort = ab; rst = r;
        #1;
        analyze(ph, a, l, p);
        exp_dout = '0;
        exp_cv   = '0;
        if (ph == 2) begin
            exp_dout[a] = b;
            exp_cv[a]   = v;
        end
        exp_v  = {exp_dout, exp_cv, (ph != 0), m_done};
        obs    = {dout, ch_valid, busy, done};
        exp_fc = m_fc[7:0];
`ifdef SEQ_FRAME_CTRL_STATUS_EN
        obs_fc = frame_cnt;
`else
        obs_fc = exp_fc;
`endif
        @(posedge clk);
        if (r) begin
            seg.delete(); m_done = 1'b0; m_fc = 0;
        end else if (ab) begin
            seg.delete(); m_done = 1'b0;
        end else if (v) begin
            seg.push_back(b);
            analyze(ph, a, l, p);
            if (ph == 3) begin
                seg.delete(); m_done = 1'b1; m_fc++;
            end else begin
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
        cyc++;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs !== 10'b0) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, 10'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL reset_idle got=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_basic_frame();
        logic [11:0] f;
        logic [2:0]  pay;
        int          npay;
        int          ndone;
        f = 12'b1011_10_011_101; pay = '0; npay = 0; ndone = 0;
        for (int idx = 0; idx < 15; idx++) begin
            if (idx < 12) cycle(f[11-idx], 1'b1, 1'b0, 1'b0);
            else          cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL basic cyc=%0d got=%b exp=%b", idx, obs, exp_v);
            end
            if (obs[5:2] == 4'b0100) begin
                pay = {pay[1:0], obs[8]}; npay++;
            end
            if (obs[0]) ndone++;
            if (idx == 12) begin
                n_cmp++;
                if (obs[1:0] !== 2'b01) begin
                    n_fail++; $display("FAIL basic_done_busy got=%b exp=01", obs[1:0]);
                end
            end
        end
        n_cmp++;
        if (npay != 3 || pay !== 3'b101 || ndone != 1) begin
            n_fail++; $display("FAIL basic_payload got=%0d/%b/%0d exp=3/101/1", npay, pay, ndone);
        end
    endtask

    task automatic test_gaps();
        logic [11:0] f;
        logic        v;
        logic [2:0]  pay;
        int          bp, g, done_at;
        f = 12'b1011_10_011_101; bp = 0; g = 0; done_at = -1; pay = '0;
        for (int idx = 0; idx < 24; idx++) begin
            v = (bp < 12) && (idx % 4 != 3);
            if (bp < 12 && !v) g++;
            cycle(v ? f[11-bp] : 1'b0, v, 1'b0, 1'b0);
            if (v) bp++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL gaps cyc=%0d got=%b exp=%b", idx, obs, exp_v);
            end
            if (obs[5:2] == 4'b0100) pay = {pay[1:0], obs[8]};
            if (obs[0] && done_at < 0) done_at = idx;
        end
        n_cmp++;
        if (done_at != 12 + g || pay !== 3'b101) begin
            n_fail++; $display("FAIL gaps_timing got=%0d/%b exp=%0d/101", done_at, pay, 12 + g);
        end
    endtask

    task automatic test_zero_len();
        logic [8:0] f;
        int         cv_seen;
        f = 9'b1011_01_000; cv_seen = 0;
        for (int idx = 0; idx < 12; idx++) begin
            if (idx < 9) cycle(f[8-idx], 1'b1, 1'b0, 1'b0);
            else         cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL zero_len cyc=%0d got=%b exp=%b", idx, obs, exp_v);
            end
            if (obs[5:2] != 4'b0) cv_seen++;
            if (idx == 9) begin
                n_cmp++;
                if (obs[1:0] !== 2'b01) begin
                    n_fail++; $display("FAIL zero_len_done got=%b exp=01", obs[1:0]);
                end
            end
        end
        n_cmp++;
        if (cv_seen != 0) begin
            n_fail++; $display("FAIL zero_len_chvalid got=%0d exp=0", cv_seen);
        end
    endtask

    task automatic test_overlap();
        logic [10:0] f;
        logic [2:0]  s;
        f = 11'b11011_00001_1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int idx = 0; idx < 14; idx++) begin
            if (idx < 11) cycle(f[10-idx], 1'b1, 1'b0, 1'b0);
            else          cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL overlap cyc=%0d got=%b exp=%b", idx, obs, exp_v);
            end
            if (idx == 4 || idx == 5) begin
                n_cmp++;
                if (obs[1] !== (idx == 5)) begin
                    n_fail++; $display("FAIL overlap_match cyc=%0d busy=%b exp=%b", idx, obs[1], idx == 5);
                end
            end
        end
        s = 3'b011;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int idx = 0; idx < 6; idx++) begin
            if (idx < 3) cycle(s[2-idx], 1'b1, 1'b0, 1'b0);
            else         cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs[1] !== 1'b0 || obs !== exp_v) begin
                n_fail++; $display("FAIL short_fill cyc=%0d got=%b exp=%b", idx, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        logic [8:0] f;
        int         ndone;
        f = 9'b1011_10_011; ndone = 0;
        for (int idx = 0; idx < 9; idx++) cycle(f[8-idx], 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int idx = 0; idx < 4; idx++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            if (idx == 0) begin
                n_cmp++;
                if (obs !== 10'b0) begin
                    n_fail++; $display("FAIL abort_next got=%b exp=%b", obs, 10'b0);
                end
            end
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL abort cyc=%0d got=%b exp=%b", idx, obs, exp_v);
            end
            if (obs[0]) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL abort_done got=%0d exp=0", ndone);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_rst_mid_header();
        logic [5:0] f;
        f = 6'b1011_10;
        for (int idx = 0; idx < 6; idx++) cycle(f[5-idx], 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== 10'b0) begin
            n_fail++; $display("FAIL rst_mid_header got=%b exp=%b", obs, 10'b0);
        end
    endtask

    task automatic test_random();
        logic b, v, ab;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int idx = 0; idx < 4000; idx++) begin
            b  = 1'($urandom % 2);
            v  = 1'(($urandom % 4) != 0);
            ab = 1'(($urandom % 97) == 0);
            cycle(b, v, ab, 1'b0);
            n_cmp++;
            if (obs !== exp_v || obs_fc !== exp_fc) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b/%0d exp=%b/%0d", idx, obs, obs_fc, exp_v, exp_fc);
            end
        end
    endtask

`ifdef SEQ_FRAME_CTRL_STATUS_EN
    task automatic test_frame_cnt();
        logic [8:0] f;
        f = 9'b1011_00_000;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 257; n++) begin
            for (int idx = 0; idx < 9; idx++) cycle(f[8-idx], 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_fc !== 8'd1 || obs_fc !== exp_fc) begin
            n_fail++; $display("FAIL frame_cnt got=%0d exp=1 model=%0d", obs_fc, exp_fc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps();
        test_zero_len();
        test_overlap();
        test_abort();
        test_rst_mid_header();
        test_random();
`ifdef SEQ_FRAME_CTRL_STATUS_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
